lpif_pipe_downsize: RTL
=======================

# lpif_pipe_downsize

Downstream consumer of the single-entry LPIF pipeline buffer: it pops full-width words from the buffer's `empty`/`rddata`/`pop` interface and serialises each one into `RATIO` narrower beats on a valid/ready output. It sits between a full-width pipeline stage and a narrower datapath such as an AIB lane adapter. It owns one holding register and a beat counter. Back-to-back words stream with no bubble.

## Interface
- `IN_WIDTH`, 32, width of the word popped from the upstream buffer.
- `OUT_WIDTH`, 8, width of one output beat. `IN_WIDTH % OUT_WIDTH == 0` is required.
- `RATIO`, `IN_WIDTH/OUT_WIDTH`, beats per word (derived, ≥1).
- `MSB_FIRST`, 0. 0 sends `in_data[OUT_WIDTH-1:0]` first; 1 sends the top slice first.
- `lclk`  input  1  clock.
- `reset`  input  1  reset, asynchronous, active-low.
- `in_empty`  input  1  upstream buffer empty. 0 means `in_data` is valid.
- `in_data`  input  IN_WIDTH  upstream buffer read data.
- `in_pop`  output  1  pop strobe to the upstream buffer, one cycle per word taken.
- `out_valid`  output  1  current beat is valid.
- `out_ready`  input  1  downstream accepts the beat.
- `out_data`  output  OUT_WIDTH  current beat.
- `out_last`  output  1  current beat is the final beat of its word.
- `busy`  output  1  holding register occupied (equals `out_valid`).

## Operation
- **State:**
  - `hold` [IN_WIDTH], reset 0.
  - `hold_valid`, reset 0.
  - `beat_cnt` [clog2(RATIO) bits, min 1], reset 0.
- **Accept:** `acc = out_valid & out_ready`.
- **Last beat:** `last = (beat_cnt == RATIO-1)`.
- **Load:** `load = ~in_empty & (~hold_valid | (acc & last))`.
  - `in_pop = load`, combinational.
  - `in_pop` is forced to 0 while `reset` is low.
- **On `load`:**
  - `hold <= in_data`, `hold_valid <= 1`, `beat_cnt <= 0`.
- **On `acc & ~last`:**
  - `beat_cnt <= beat_cnt + 1`.
- **On `acc & last & ~load`:**
  - `hold_valid <= 0`, `beat_cnt <= 0`.
  - `hold` retains its value.
- **Output decode:**
  - `out_valid = hold_valid`.
  - `out_last = hold_valid & last`.
  - `out_data = hold[k*OUT_WIDTH +: OUT_WIDTH]`, where `k = beat_cnt` if `MSB_FIRST=0`, else `RATIO-1-beat_cnt`.
- **Two-state machine:**
  - IDLE (`hold_valid=0`) → SEND on `~in_empty`.
  - SEND → SEND on `acc & last & ~in_empty`, which reloads seamlessly.
  - SEND → IDLE on `acc & last & in_empty`.
- **Upstream interaction:**
  - The buffer's `empty` updates one cycle after `pop`, but the block never samples `in_empty` the cycle after a load unless `RATIO==1` and a last-beat accept occurs.
  - In that case `in_empty` is already updated: 1 if the buffer drained, 0 if it was refilled by a same-cycle push/pop. Both cases are correct by construction.
- **Reset mid-word:** the partial word is discarded. Outputs return to their reset values asynchronously.

## Timing
- **Reset values:**
  - `in_pop=0`, `out_valid=0`, `out_last=0`, `busy=0`, `out_data=0`.
- **Latency:** `in_empty` falls in cycle t while IDLE → `in_pop=1` in cycle t → beat 0 presented with `out_valid=1` in cycle t+1.
- **Throughput:** with `out_ready` held high and input always available, one beat per cycle and zero idle cycles between words.
  - The pop for word n+1 coincides with the accept of word n's last beat.
- **Stall:** `out_ready=0` holds `out_valid`, `out_data`, `out_last` and `beat_cnt` stable. No pop occurs while SEND and not on the last-beat accept.
- **Handshake rule:** `out_valid` never drops without an accept. `in_pop` is never asserted while `in_empty=1`.
- **`RATIO==1`:** degenerates to a one-entry pass-through register with `out_last` always 1 when valid.

## Test plan
- **Single word:** reset, then present `in_data=32'hDDCCBBAA`, `in_empty=0`, `out_ready=1`, `MSB_FIRST=0`.
  - `in_pop` pulses one cycle.
  - Beats `AA`, `BB`, `CC`, `DD` on cycles t+1..t+4, with `out_last` only on `DD`.
  - `out_valid=0` at t+5.
- **Back-to-back:** `32'h03020100` then `32'h07060504` available continuously.
  - Output is `00..07` on 8 consecutive cycles.
  - The second `in_pop` is on the cycle `03` is accepted.
- **Backpressure:** drop `out_ready` for 3 cycles after beat 1.
  - `out_data` stays `BB` and `beat_cnt` holds.
  - No `in_pop` during the stall.
  - Beats resume in order.
- **MSB_FIRST=1:** word `32'h11223344` → beats `11`, `22`, `33`, `44`.
- **Reset mid-word:** assert `reset` low after beat 1 accepted.
  - All outputs are 0 immediately.
  - After release with a new word `32'hA5A5A5A5`, 4 beats of `A5` with no residual data from the old word.
- **Empty upstream after last beat:** `in_empty=1` when `DD` is accepted.
  - `out_valid=0` next cycle and `in_pop` stays 0.
  - A later word loads with 1-cycle latency.

Source files
------------

// File: rtl/lpif_pipe_downsize.sv
// Serialises full-width words popped from the LPIF pipeline buffer into RATIO narrow
// valid/ready beats, reloading on the last-beat accept so consecutive words stream with no bubble.
module lpif_pipe_downsize #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 lclk,
  input  logic                 reset,
  input  logic                 in_empty,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned     RATIO   = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned     CntW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(RATIO - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
  logic                hold_valid, acc, last, load;
  int unsigned         slice;

  assign hold_valid = (state_q == StSend);
  assign acc        = hold_valid & out_ready;
  assign last       = (beat_cnt_q == LastCnt);
  assign load       = ~in_empty & (~hold_valid | (acc & last));

  // Pop is masked during reset so the buffer never loses a word the holding register ignored.
  assign in_pop    = load & reset;
  assign out_valid = hold_valid;
  assign busy      = hold_valid;
  assign out_last  = hold_valid & last;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (!in_empty) begin
          state_d    = StSend;
          hold_d     = in_data;
          beat_cnt_d = '0;
        end
      end
      StSend: begin
        if (acc && last) begin
          beat_cnt_d = '0;
          // Seamless reload on the last beat; otherwise hold keeps its stale contents.
          if (!in_empty) begin
            hold_d = in_data;
          end else begin
            state_d = StIdle;
          end
        end else if (acc) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    slice    = MSB_FIRST ? (RATIO - 1 - 32'(beat_cnt_q)) : 32'(beat_cnt_q);
    out_data = hold_q[slice*OUT_WIDTH +: OUT_WIDTH];
  end

  always_ff @(posedge lclk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
